uc_escalonador_quadro: RTL

- Frame scheduler for the game datapath.
- On each periodic game tick it runs the three movement/check controllers in a fixed order: shots, then asteroids, then collision check.
- Issues one-cycle start pulses, waits for each done pulse, and owns the select of the shared position-memory mux so only the active controller drives it.
- Sits between the top-level game FSM and the per-object controllers.

---
 rtl/uc_escalonador_quadro_pkg.sv | 32 +++
 rtl/uc_escalonador_quadro_if.sv | 22 ++
 rtl/uc_escalonador_quadro_tick.sv | 57 +++++
 rtl/uc_escalonador_quadro.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uc_escalonador_quadro_pkg.sv
// Shared definitions for the frame scheduler: state codes and position-memory owner codes.
package uc_escalonador_quadro_pkg;

    typedef enum logic [3:0] {
        INICIO          = 4'd0,
        ESPERA          = 4'd1,
        DISPARA_TIROS   = 4'd2,
        AGUARDA_TIROS   = 4'd3,
        DISPARA_ASTE    = 4'd4,
        AGUARDA_ASTE    = 4'd5,
        DISPARA_COLISAO = 4'd6,
        AGUARDA_COLISAO = 4'd7,
        FIM_QUADRO      = 4'd8,
        ERRO            = 4'd15
    } estado_t;

    localparam logic [1:0] SEL_NENHUM  = 2'b00;
    localparam logic [1:0] SEL_TIROS   = 2'b01;
    localparam logic [1:0] SEL_ASTE    = 2'b10;
    localparam logic [1:0] SEL_COLISAO = 2'b11;

    // Owner of the shared position memory for a given scheduler state.
    function automatic logic [1:0] dono_memoria(estado_t estado);
        case (estado)
            DISPARA_TIROS, AGUARDA_TIROS:     return SEL_TIROS;
            DISPARA_ASTE, AGUARDA_ASTE:       return SEL_ASTE;
            DISPARA_COLISAO, AGUARDA_COLISAO: return SEL_COLISAO;
            default:                          return SEL_NENHUM;
        endcase
    endfunction

endpackage

// File: rtl/uc_escalonador_quadro_if.sv
// Start/done handshake and memory-select bundle between the scheduler and the object controllers.
interface uc_escalonador_quadro_if;

    logic       movimenta_tiros;
    logic       movimenta_aste;
    logic       verifica_colisao;
    logic       tiros_concluido;
    logic       aste_concluido;
    logic       colisao_concluido;
    logic [1:0] sel_mem;

    modport master (
        output movimenta_tiros, movimenta_aste, verifica_colisao, sel_mem,
        input  tiros_concluido, aste_concluido, colisao_concluido
    );

    modport slave (
        input  movimenta_tiros, movimenta_aste, verifica_colisao, sel_mem,
        output tiros_concluido, aste_concluido, colisao_concluido
    );

endinterface

// File: rtl/uc_escalonador_quadro_tick.sv
// contador_tick_quadro: frame-period counter, single-slot pending tick and sticky overrun flag.
module contador_tick_quadro #(
    parameter int unsigned TICK_CICLOS = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic jogo_ativo,
    input  logic pausa,
    input  logic em_espera,
    input  logic consome_tick,
    output logic tick_pendente,
    output logic quadro_atrasado
);

    localparam int unsigned CW = $clog2(TICK_CICLOS);
    localparam logic [CW-1:0] ULTIMO = CW'(TICK_CICLOS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_pendente_q, tick_pendente_d;
    logic          quadro_atrasado_q, quadro_atrasado_d;

    // A wrap in the same cycle as the consume leaves the new tick pending.
    always_comb begin
        cnt_d             = cnt_q;
        tick_pendente_d   = tick_pendente_q;
        quadro_atrasado_d = quadro_atrasado_q;
        if (consome_tick) tick_pendente_d = 1'b0;
        if (!jogo_ativo) begin
            cnt_d           = '0;
            tick_pendente_d = 1'b0;
        end else if (!pausa) begin
            if (cnt_q == ULTIMO) begin
                cnt_d           = '0;
                tick_pendente_d = 1'b1;
                if (!em_espera) quadro_atrasado_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q             <= '0;
            tick_pendente_q   <= 1'b0;
            quadro_atrasado_q <= 1'b0;
        end else begin
            cnt_q             <= cnt_d;
            tick_pendente_q   <= tick_pendente_d;
            quadro_atrasado_q <= quadro_atrasado_d;
        end
    end

    assign tick_pendente   = tick_pendente_q;
    assign quadro_atrasado = quadro_atrasado_q;

endmodule

// File: rtl/uc_escalonador_quadro.sv
// Frame scheduler: per tick runs shots, asteroids, collision in order and owns sel_mem.
// Optional done watchdog enabled by defining ESCALONADOR_TIMEOUT_EN.
module uc_escalonador_quadro
    import uc_escalonador_quadro_pkg::*;
#(
    parameter int unsigned TICK_CICLOS    = 50000000,
    parameter int unsigned TIMEOUT_CICLOS = 4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          jogo_ativo,
    input  logic                          pausa,
    uc_escalonador_quadro_if.master       ctl,
    output logic                          quadro_concluido,
    output logic                          quadro_atrasado,
    output logic [7:0]                    contador_quadros,
    output logic                          erro_escalonador,
    output logic [3:0]                    db_estado
);

    if (TICK_CICLOS < 2 || TIMEOUT_CICLOS < 1) begin : g_parametros_invalidos
        $error("uc_escalonador_quadro: TICK_CICLOS must be >= 2 and TIMEOUT_CICLOS >= 1");
    end

    estado_t    estado_q, estado_d;
    logic [7:0] contador_q, contador_d;
    logic       tick_pendente;
    logic       consome_tick;
    logic       estouro;

    contador_tick_quadro #(
        .TICK_CICLOS(TICK_CICLOS)
    ) u_tick (
        .clock          (clock),
        .reset          (reset),
        .jogo_ativo     (jogo_ativo),
        .pausa          (pausa),
        .em_espera      (estado_q == ESPERA),
        .consome_tick   (consome_tick),
        .tick_pendente  (tick_pendente),
        .quadro_atrasado(quadro_atrasado)
    );

`ifdef ESCALONADOR_TIMEOUT_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT_CICLOS + 1) > 12) ? $clog2(TIMEOUT_CICLOS + 1) : 12;
    localparam logic [WD_W-1:0] WD_LIMITE = WD_W'(TIMEOUT_CICLOS - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            aguardando;

    // Held at zero outside AGUARDA, so every entry starts a fresh count.
    always_comb begin
        aguardando = (estado_q == AGUARDA_TIROS) || (estado_q == AGUARDA_ASTE) ||
                     (estado_q == AGUARDA_COLISAO);
        wd_d       = aguardando ? wd_q + 1'b1 : '0;
        estouro    = aguardando && (wd_q == WD_LIMITE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign erro_escalonador = (estado_q == ERRO);
`else
    assign estouro          = 1'b0;
    assign erro_escalonador = 1'b0;
`endif

    always_comb begin
        estado_d     = estado_q;
        consome_tick = 1'b0;
        case (estado_q)
            INICIO: estado_d = ESPERA;
            ESPERA: begin
                if (tick_pendente && jogo_ativo && !pausa) begin
                    estado_d     = DISPARA_TIROS;
                    consome_tick = 1'b1;
                end
            end
            DISPARA_TIROS: estado_d = AGUARDA_TIROS;
            AGUARDA_TIROS: begin
                if (ctl.tiros_concluido) estado_d = DISPARA_ASTE;
                else if (estouro)        estado_d = ERRO;
            end
            DISPARA_ASTE: estado_d = AGUARDA_ASTE;
            AGUARDA_ASTE: begin
                if (ctl.aste_concluido) estado_d = DISPARA_COLISAO;
                else if (estouro)       estado_d = ERRO;
            end
            DISPARA_COLISAO: estado_d = AGUARDA_COLISAO;
            AGUARDA_COLISAO: begin
                if (ctl.colisao_concluido) estado_d = FIM_QUADRO;
                else if (estouro)          estado_d = ERRO;
            end
            FIM_QUADRO: estado_d = ESPERA;
            ERRO:       estado_d = ERRO;
            default:    estado_d = INICIO;
        endcase
    end

    always_comb begin
        contador_d = contador_q;
        if (estado_q == FIM_QUADRO) contador_d = contador_q + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIO;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
        end
    end

    assign ctl.movimenta_tiros  = (estado_q == DISPARA_TIROS);
    assign ctl.movimenta_aste   = (estado_q == DISPARA_ASTE);
    assign ctl.verifica_colisao = (estado_q == DISPARA_COLISAO);
    assign ctl.sel_mem          = dono_memoria(estado_q);
    assign quadro_concluido     = (estado_q == FIM_QUADRO);
    assign contador_quadros     = contador_q;
    assign db_estado            = estado_q;

endmodule
